l2_miss_arbiter: RTL

//  Shares the single L2-cache wishbone slave port between the icache and dcache miss ports.

---
 rtl/l2_miss_arbiter_pkg.sv | 45 ++++
 rtl/l2_miss_arbiter_if.sv | 28 ++
 rtl/l2_miss_arbiter_wb_port_mux.sv | 53 +++++
 rtl/l2_miss_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/l2_miss_arbiter_pkg.sv
// Shared types and width constants for the L2 miss arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie break in place
// of fixed dcache priority).
package l2_miss_arbiter_pkg;

    // Default wishbone widths: one 128-bit line, line address ADR[15:4].
    localparam int LINE_W = 128;
    localparam int ADR_W  = 12;
    localparam int SEL_W  = LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // Winner of an arbitration round. Only meaningful when at least one
    // request is present; the caller qualifies it with req_i | req_d.
    function automatic arb_src_t pick_winner(
        input logic     req_i,
        input logic     req_d,
        input arb_src_t last_gnt,
        input logic     rr_en
    );
        arb_src_t win;
        if (req_i && req_d) begin
            if (rr_en) begin
                win = (last_gnt == SRC_D) ? SRC_I : SRC_D;
            end else begin
                win = SRC_D;
            end
        end else if (req_d) begin
            win = SRC_D;
        end else begin
            win = SRC_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/l2_miss_arbiter_if.sv
// Wishbone line-transfer interface used on both L1 miss ports and the L2 port.
// The master modport is the side that drives CYC/STB; slave answers with
// DAT_S/ACK/RTY.
interface l2_miss_arbiter_if #(
    parameter int LINE_W = l2_miss_arbiter_pkg::LINE_W,
    parameter int ADR_W  = l2_miss_arbiter_pkg::ADR_W,
    parameter int SEL_W  = l2_miss_arbiter_pkg::SEL_W
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADR_W-1:0]  adr;
    logic [LINE_W-1:0] dat_m;
    logic [LINE_W-1:0] dat_s;
    logic              ack;
    logic              rty;

    modport master (
        output cyc, stb, we, sel, adr, dat_m,
        input  dat_s, ack, rty
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m,
        output dat_s, ack, rty
    );
endinterface

// File: rtl/l2_miss_arbiter_wb_port_mux.sv
// Combinational 2:1 steering between the icache and dcache miss ports and the
// single L2 port. Request signals follow the selected master only while a
// grant is valid; ACK/RTY are returned only to that master. Read data is
// broadcast because it is qualified by ACK at the receiver.
module l2_miss_arbiter_wb_port_mux
    import l2_miss_arbiter_pkg::*;
(
    input  logic             gnt_valid,
    input  arb_src_t         src,
    l2_miss_arbiter_if.slave  icache,
    l2_miss_arbiter_if.slave  dcache,
    l2_miss_arbiter_if.master l2
);

    // Steer requests to L2 and route the termination back to the owner.
    always_comb begin
        l2.cyc     = 1'b0;
        l2.stb     = 1'b0;
        l2.we      = 1'b0;
        l2.sel     = '0;
        l2.adr     = '0;
        l2.dat_m   = '0;
        icache.ack = 1'b0;
        icache.rty = 1'b0;
        dcache.ack = 1'b0;
        dcache.rty = 1'b0;
        if (gnt_valid) begin
            if (src == SRC_D) begin
                l2.cyc     = dcache.cyc;
                l2.stb     = dcache.stb;
                l2.we      = dcache.we;
                l2.sel     = dcache.sel;
                l2.adr     = dcache.adr;
                l2.dat_m   = dcache.dat_m;
                dcache.ack = l2.ack;
                dcache.rty = l2.rty;
            end else begin
                l2.cyc     = icache.cyc;
                l2.stb     = icache.stb;
                l2.we      = icache.we;
                l2.sel     = icache.sel;
                l2.adr     = icache.adr;
                l2.dat_m   = icache.dat_m;
                icache.ack = l2.ack;
                icache.rty = l2.rty;
            end
        end
    end

    assign icache.dat_s = l2.dat_s;
    assign dcache.dat_s = l2.dat_s;

endmodule

// File: rtl/l2_miss_arbiter.sv
// Arbitrates the icache and dcache miss ports onto the single L2 wishbone
// port. One grant per transaction; the grant is released when the L2 answers
// with ACK or RTY, or when the owner drops CYC.
// Build macro: ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the master
// that was not granted last; otherwise dcache always wins a tie.
module l2_miss_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    l2_miss_arbiter_if.slave  icache,
    l2_miss_arbiter_if.slave  dcache,
    l2_miss_arbiter_if.master l2
);
    import l2_miss_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    // last_gnt_reg is still maintained so both builds share one FSM.
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t state_reg;
    arb_src_t   last_gnt_reg;

    logic     req_i;
    logic     req_d;
    logic     gnt_valid;
    logic     owner_cyc;
    logic     gnt_done;
    arb_src_t gnt_src;
    arb_src_t winner;

    assign req_i = icache.cyc & icache.stb;
    assign req_d = dcache.cyc & dcache.stb;

    assign winner = pick_winner(req_i, req_d, last_gnt_reg, RR_EN);

    // Grant qualifier: outputs are only driven while a master owns the port.
    assign gnt_valid = (state_reg != IDLE);
    assign gnt_src   = (state_reg == GNT_D) ? SRC_D : SRC_I;

    // The transaction ends on a termination from L2 or an abort by the owner.
    assign owner_cyc = (gnt_src == SRC_D) ? dcache.cyc : icache.cyc;
    assign gnt_done  = l2.ack | l2.rty | ~owner_cyc;

    // Grant FSM: arbitrate in IDLE, hold the grant until the transaction ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_gnt_reg <= SRC_D;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_i || req_d) begin
                        state_reg <= (winner == SRC_D) ? GNT_D : GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (gnt_done) begin
                        state_reg    <= IDLE;
                        last_gnt_reg <= gnt_src;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    l2_miss_arbiter_wb_port_mux u_mux (
        .gnt_valid (gnt_valid),
        .src       (gnt_src),
        .icache    (icache),
        .dcache    (dcache),
        .l2        (l2)
    );

endmodule
